// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the processor bus and the registered-read data memory.
// Optional write guard for the reserved scalar region: define DMEM_WRITE_GUARD_EN.
module dmem_access_ctrl #(
   parameter int          N            = 17,
   parameter logic [11:0] PROTECT_BASE = 12'd4089
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [11:0]  req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [11:0]  rsp_data,
   output logic         rsp_err,
   output logic         mem_write_en,
   output logic [11:0]  mem_addr,
   output logic [N-1:0] mem_datain,
   input  logic [11:0]  mem_dataout
);

`ifdef DMEM_WRITE_GUARD_EN
   localparam bit GuardEn = 1'b1;
`else
   localparam bit GuardEn = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      CAPTURE,
      RESP
   } state_t;

   state_t         state_q;
   logic           req_ready_q;
   logic           rsp_valid_q;
   logic [11:0]    rsp_data_q;
   logic           rsp_err_q;
   logic           mem_write_en_q;
   logic [11:0]    mem_addr_q;
   logic [N-1:0]   mem_datain_q;
   logic           blocked_q;
   logic           blocked_d;

   // A store into the reserved scalar region is suppressed when the guard is built in.
   always_comb begin
      blocked_d = GuardEn && req_write && (req_addr >= PROTECT_BASE);
   end

   // Memory read data is only valid the cycle after READ, so it is sampled in CAPTURE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         req_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= 12'd0;
         rsp_err_q      <= 1'b0;
         mem_write_en_q <= 1'b0;
         mem_addr_q     <= 12'd0;
         mem_datain_q   <= '0;
         blocked_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  mem_addr_q  <= req_addr;
                  blocked_q   <= blocked_d;
                  if (req_write) begin
                     mem_write_en_q <= ~blocked_d;
                     mem_datain_q   <= req_wdata;
                     state_q        <= WRITE;
                  end else begin
                     mem_write_en_q <= 1'b0;
                     state_q        <= READ;
                  end
               end
            end
            WRITE: begin
               mem_write_en_q <= 1'b0;
               rsp_data_q     <= 12'd0;
               rsp_err_q      <= blocked_q;
               rsp_valid_q    <= 1'b1;
               state_q        <= RESP;
            end
            READ: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               rsp_data_q  <= mem_dataout;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign mem_write_en = mem_write_en_q;
   assign mem_addr     = mem_addr_q;
   assign mem_datain   = mem_datain_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: registered-read memory, transaction-level model and directed accesses.
module tb_dmem_access_ctrl;

   localparam int          N            = 17;
   localparam logic [11:0] PROTECT_BASE = 12'd4089;

`ifdef DMEM_WRITE_GUARD_EN
   localparam bit GuardOn = 1'b1;
`else
   localparam bit GuardOn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [11:0]  req_addr = 12'd0;
   logic [N-1:0] req_wdata = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [11:0]  rsp_data;
   logic         rsp_err;
   logic         mem_write_en;
   logic [11:0]  mem_addr;
   logic [N-1:0] mem_datain;
   logic [11:0]  mem_dataout;

   int errors = 0;
   int checks = 0;

   dmem_access_ctrl #(.N(N), .PROTECT_BASE(PROTECT_BASE)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_datain   (mem_datain),
      .mem_dataout  (mem_dataout)
   );

   always #5 clk = ~clk;

   // Data memory: writes on write_en, otherwise registers the addressed word.
   logic [11:0] memArr [4096];
   logic [11:0] refMem [4096];

   always @(posedge clk) begin
      if (mem_write_en) memArr[mem_addr] <= mem_datain[11:0];
      else              mem_dataout      <= memArr[mem_addr];
   end

   initial begin
      for (int a = 0; a < 4096; a++) begin
         memArr[a] = 12'd0;
         refMem[a] = 12'd0;
      end
      memArr[4]   = 12'd1;  refMem[4]   = 12'd1;
      memArr[5]   = 12'd2;  refMem[5]   = 12'd2;
      memArr[323] = 12'd8;  refMem[323] = 12'd8;
   end

   // Transaction model: an accepted request answers after a fixed number of edges
   // (store 2, load 3, counting the accept edge) and is retired by rsp_ready.
   bit          mBusy = 1'b0;
   bit          mRespValid = 1'b0;
   bit          mWrite = 1'b0;
   bit          mBlocked = 1'b0;
   int          mCnt = 0;
   int          mLat = 0;
   logic [11:0] mAddr = 12'd0;
   logic [11:0] mWdata = 12'd0;
   logic [11:0] mData = 12'd0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBusy      <= 1'b0;
         mRespValid <= 1'b0;
         mBlocked   <= 1'b0;
         mCnt       <= 0;
      end else if (!mBusy) begin
         if (req_valid) begin
            mBusy    <= 1'b1;
            mCnt     <= 1;
            mWrite   <= req_write;
            mAddr    <= req_addr;
            mWdata   <= req_wdata[11:0];
            mBlocked <= GuardOn && req_write && (req_addr >= PROTECT_BASE);
            mLat     <= req_write ? 2 : 3;
         end
      end else if (mRespValid) begin
         if (rsp_ready) begin
            mRespValid <= 1'b0;
            mBusy      <= 1'b0;
         end
      end else begin
         mCnt <= mCnt + 1;
         if (mCnt + 1 == mLat) begin
            mRespValid <= 1'b1;
            if (mWrite) begin
               mData <= 12'd0;
               if (!mBlocked) refMem[mAddr] <= mWdata;
            end else begin
               mData <= refMem[mAddr];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("req_ready", {31'd0, req_ready}, {31'd0, !mBusy});
         checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, mRespValid});
         checkOutput("mem_write_en", {31'd0, mem_write_en},
                     {31'd0, mBusy && mWrite && !mBlocked && (mCnt == 1) && !mRespValid});
         if (mBusy) checkOutput("mem_addr", {20'd0, mem_addr}, {20'd0, mAddr});
         if (mRespValid) begin
            checkOutput("rsp_data", {20'd0, rsp_data}, {20'd0, mData});
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, mBlocked});
         end
      end
   end

   // One complete access; stall holds rsp_ready low while injecting a competing request.
   task automatic applyStimulus(input bit wr, input logic [11:0] addr, input logic [N-1:0] wdata,
                                input int stall, output logic [11:0] data, output logic err,
                                output int lat);
      int t;
      logic [11:0] held;
      @(negedge clk);
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
      held = rsp_data;
      for (int s = 0; s < stall; s++) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = addr + 12'd1;
         req_wdata = '1;
         @(negedge clk);
         checkOutput("stall_rsp_data", {20'd0, rsp_data}, {20'd0, held});
         checkOutput("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      data      = rsp_data;
      err       = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [11:0] d;
      logic        e;
      int          l;

      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("reset_rsp_data", {20'd0, rsp_data}, 32'd0);
      checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      checkOutput("reset_mem_we", {31'd0, mem_write_en}, 32'd0);
      checkOutput("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
      checkOutput("reset_mem_datain", {15'd0, mem_datain}, 32'd0);
      rst = 1'b0;

      applyStimulus(1'b1, 12'd10, 17'h000AB, 0, d, e, l);
      checkOutput("store10_data", {20'd0, d}, 32'h0);
      checkOutput("store10_lat", l, 32'd2);
      applyStimulus(1'b0, 12'd10, '0, 0, d, e, l);
      checkOutput("load10_data", {20'd0, d}, 32'h0AB);
      checkOutput("load10_lat", l, 32'd3);

      applyStimulus(1'b0, 12'd4, '0, 0, d, e, l);
      checkOutput("load4_data", {20'd0, d}, 32'd1);
      applyStimulus(1'b0, 12'd323, '0, 0, d, e, l);
      checkOutput("load323_data", {20'd0, d}, 32'd8);

      applyStimulus(1'b1, 12'd20, 17'h1F123, 0, d, e, l);
      applyStimulus(1'b0, 12'd20, '0, 0, d, e, l);
      checkOutput("load20_data", {20'd0, d}, 32'h123);

      applyStimulus(1'b0, 12'd5, '0, 3, d, e, l);
      checkOutput("load5_stall_data", {20'd0, d}, 32'd2);
      applyStimulus(1'b0, 12'd6, '0, 0, d, e, l);
      checkOutput("load6_untouched", {20'd0, d}, 32'd0);

      // Reset lands while the store's write edge is still pending.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 12'd5;
      req_wdata = 17'h00777;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("pre_reset_we", {31'd0, mem_write_en}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_we_drop", {31'd0, mem_write_en}, 32'd0);
      checkOutput("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("async_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 12'd5, '0, 0, d, e, l);
      checkOutput("load5_after_reset", {20'd0, d}, 32'd2);

      applyStimulus(1'b1, 12'd4094, 17'd7, 0, d, e, l);
      checkOutput("store4094_err", {31'd0, e}, {31'd0, GuardOn});
      applyStimulus(1'b0, 12'd4094, '0, 0, d, e, l);
      checkOutput("load4094_data", {20'd0, d}, GuardOn ? 32'd0 : 32'd7);
      checkOutput("load4094_err", {31'd0, e}, 32'd0);
      applyStimulus(1'b1, 12'd4088, 17'h00055, 0, d, e, l);
      checkOutput("store4088_err", {31'd0, e}, 32'd0);
      applyStimulus(1'b0, 12'd4088, '0, 0, d, e, l);
      checkOutput("load4088_data", {20'd0, d}, 32'h055);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
